// File: rtl/prng_share_ctrl_pkg.sv
// Shared definitions for the PRNG share controller: controller states, word type
// and a small width helper used for requester index vectors.
package prng_share_ctrl_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        GEN_RST = 2'd0,
        WARM    = 2'd1,
        SERVE   = 2'd2
    } ctrl_state_e;

    // Bits needed to index n requesters; never zero so vectors stay legal for n=1.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prng_share_ctrl_if.sv
// Bundle between the PRNG share controller (slave), its generator stage and the
// consumer blocks (master side drives generator word, reseed and requests).
interface prng_share_ctrl_if
    import prng_share_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CNTW = 16
);

    word_t            gen_word;
    logic             gen_rst;
    logic             reseed;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  ack;
    word_t            rnd_data;
    logic             ready;
    logic [CNTW-1:0]  served_cnt;

    modport master (
        output gen_word, reseed, req,
        input  gen_rst, ack, rnd_data, ready, served_cnt
    );

    modport slave (
        input  gen_word, reseed, req,
        output gen_rst, ack, rnd_data, ready, served_cnt
    );

endinterface

// File: rtl/prng_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after the
// pointer, wrapping around, and returns it both one-hot and as an index.
module rr_arbiter
    import prng_share_ctrl_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld
);

    logic [IW-1:0] idx;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves
        // a value unassigned and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((32'(ptr) + 32'(k)) % 32'(N));
            if (!grant_vld && req[idx]) begin
                grant_vld  = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prng_share_ctrl.sv
// Sequences a shared 32-bit PRNG stage (reset, warm-up discard) and hands out one
// generator word per cycle to NREQ requesters in round-robin order.
module prng_share_ctrl
    import prng_share_ctrl_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WARMUP = 16,
    parameter int CNTW   = 16
) (
    input  logic             clk,
    input  logic             rst,
    prng_share_ctrl_if.slave bus
);

    localparam int IW  = idx_w(NREQ);
    localparam int WCW = 8;

    ctrl_state_e     state, state_nxt;
    logic [WCW-1:0]  warm_cnt, warm_cnt_nxt;
    logic [IW-1:0]   ptr;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            grant_vld;
    logic            do_grant;
    logic [NREQ-1:0] ack_q;
    word_t           data_q;
    logic [CNTW-1:0] cnt_q;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req       (bus.req),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    always_comb begin
        state_nxt    = state;
        warm_cnt_nxt = warm_cnt;
        do_grant     = 1'b0;
        unique case (state)
            GEN_RST: begin
                warm_cnt_nxt = '0;
                state_nxt    = (WARMUP == 0) ? SERVE : WARM;
            end
            WARM: begin
                warm_cnt_nxt = warm_cnt + WCW'(1);
                if (warm_cnt == WCW'(WARMUP - 1)) begin
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                do_grant = grant_vld;
            end
            default: begin
                state_nxt = GEN_RST;
            end
        endcase
        // A reseed restarts the generator and suppresses any grant in the same cycle.
        if (bus.reseed) begin
            state_nxt = GEN_RST;
            do_grant  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the pre-edge values and the order of statements does not matter.
        if (rst) begin
            // NOTE: the data-path registers are reset too, because rnd_data is
            // defined to read zero straight after reset.
            state    <= GEN_RST;
            warm_cnt <= '0;
            ptr      <= '0;
            ack_q    <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state    <= state_nxt;
            warm_cnt <= warm_cnt_nxt;
            ack_q    <= do_grant ? grant : '0;
            if (do_grant) begin
                data_q <= bus.gen_word;
                ptr    <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
                cnt_q  <= cnt_q + CNTW'(1);
            end
        end
    end

    assign bus.gen_rst    = (state == GEN_RST);
    assign bus.ready      = (state == SERVE);
    assign bus.ack        = ack_q;
    assign bus.rnd_data   = data_q;
    assign bus.served_cnt = cnt_q;

    // An ack is always a single requester and only follows a cycle spent serving.
    a_ack_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(ack_q));
    a_ack_after_serve : assert property (@(posedge clk) disable iff (rst)
        (ack_q != '0) |-> ($past(state) == SERVE));

endmodule

// File: tb/tb_prng_share_ctrl.sv
// Bench for prng_share_ctrl: a countdown/queue reference model predicts grants,
// a negedge monitor compares; a second instance covers WARMUP=0 and counter wrap.
module tb_prng_share_ctrl;
    import prng_share_ctrl_pkg::*;

    localparam int NREQ   = 4;
    localparam int WARMUP = 16;
    localparam int CNTW   = 16;

    logic clk = 1'b0;
    logic rst;
    logic rst_b;

    always #5 clk = ~clk;

    prng_share_ctrl_if #(.NREQ(NREQ), .CNTW(CNTW)) bus ();
    prng_share_ctrl_if #(.NREQ(2), .CNTW(4)) bus_b ();

    prng_share_ctrl #(.NREQ(NREQ), .WARMUP(WARMUP), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    prng_share_ctrl #(.NREQ(2), .WARMUP(0), .CNTW(4)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    assign bus_b.gen_word = bus.gen_word;

    typedef struct {
        int              idx;
        word_t           data;
        logic [CNTW-1:0] cnt;
        int              cyc;
    } exp_t;

    exp_t            sb[$];
    int              n_checks = 0;
    int              n_pass   = 0;
    int              cyc      = 0;
    bit              model_on = 1'b0;

    // Reference model: cycles left before serving, last delivered word, pointer, count.
    int              countdown;
    int              m_ptr;
    logic [CNTW-1:0] m_cnt;
    word_t           m_data;
    logic            exp_gen_rst;
    logic            exp_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge(input logic r, input logic rs, input logic [NREQ-1:0] rq,
                              input word_t w);
        int best;
        int best_d;
        int d;
        if (r) begin
            model_on  = 1'b1;
            countdown = WARMUP + 1;
            m_ptr     = 0;
            m_cnt     = '0;
            m_data    = '0;
        end else if (rs) begin
            countdown = WARMUP + 1;
        end else if (countdown > 0) begin
            countdown--;
        end else if (rq != '0) begin
            // Winner is the requesting index at the smallest cyclic distance from the pointer.
            best   = -1;
            best_d = NREQ;
            for (int i = 0; i < NREQ; i++) begin
                d = (i - m_ptr + NREQ) % NREQ;
                if (rq[i] && d < best_d) begin
                    best   = i;
                    best_d = d;
                end
            end
            m_ptr  = (best + 1) % NREQ;
            m_data = w;
            m_cnt  = m_cnt + CNTW'(1);
            sb.push_back('{idx: best, data: w, cnt: m_cnt, cyc: cyc});
        end
        exp_gen_rst = (countdown == WARMUP + 1);
        exp_ready   = (countdown == 0);
    endtask

    task automatic step(input logic r, input logic rs, input logic [NREQ-1:0] rq);
        rst        = r;
        bus.reseed = rs;
        bus.req    = rq;
        bus.gen_word = $urandom;
        @(posedge clk);
        cyc++;
        model_edge(r, rs, rq, bus.gen_word);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (model_on) begin
            check("gen_rst", 64'(bus.gen_rst), 64'(exp_gen_rst));
            check("ready", 64'(bus.ready), 64'(exp_ready));
            check("rnd_data", 64'(bus.rnd_data), 64'(m_data));
            check("served_cnt", 64'(bus.served_cnt), 64'(m_cnt));
            if (bus.ack != '0) begin
                if (sb.size() == 0) begin
                    check("ack_unexpected", 64'(bus.ack), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("ack", 64'(bus.ack), 64'(1) << e.idx);
                    check("ack_cycle", 64'(cyc), 64'(e.cyc));
                    check("ack_data", 64'(bus.rnd_data), 64'(e.data));
                    check("ack_cnt", 64'(bus.served_cnt), 64'(e.cnt));
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check("ack_missing", 64'(bus.ack), 64'(1) << e.idx);
            end
        end
    end

    initial begin
        logic            r_rand;
        logic            rs_rand;
        logic [NREQ-1:0] hold;
        logic [1:0]      exp_ack_b;

        rst          = 1'b1;
        bus.reseed   = 1'b0;
        bus.req      = '0;
        bus.gen_word = '0;
        rst_b        = 1'b1;
        bus_b.reseed = 1'b0;
        bus_b.req    = '0;

        // Reset, then idle through warm-up: gen_rst one cycle, ready after 17.
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0);

        // All requesters held: strict rotation 0,1,2,3,0...
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 4'b1111);

        // Move pointer to 2, then requesters 0 and 1 compete.
        step(1'b0, 1'b0, 4'b0010);
        step(1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 4'b0011);
        step(1'b0, 1'b0, 4'b0010);
        step(1'b0, 1'b0, 4'b0000);

        // Reseed colliding with a request: no ack, full warm-up, then the grant.
        step(1'b0, 1'b1, 4'b0100);
        for (int i = 0; i < WARMUP + 2; i++) step(1'b0, 1'b0, 4'b0100);
        step(1'b0, 1'b0, 4'b0000);

        // Reseed repeated while the generator is held in reset.
        step(1'b0, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 4'b0000);
        for (int i = 0; i < WARMUP + 3; i++) step(1'b0, 1'b0, 4'b0000);

        // Random levels, occasional reseed and reset.
        for (int i = 0; i < 600; i++) begin
            r_rand  = ($urandom_range(0, 299) == 0);
            rs_rand = ($urandom_range(0, 79) == 0);
            step(r_rand, rs_rand, NREQ'($urandom_range(0, (1 << NREQ) - 1)));
        end

        // Well-behaved requesters: hold until acked, then drop.
        hold = '0;
        for (int i = 0; i < 400; i++) begin
            hold = hold & ~bus.ack;
            hold = hold | NREQ'($urandom_range(0, (1 << NREQ) - 1));
            hold = hold & ~bus.ack;
            step(1'b0, ($urandom_range(0, 149) == 0), hold);
        end

        // Reset in the middle of serving with everybody requesting.
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < WARMUP + 1; i++) step(1'b0, 1'b0, 4'b1111);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b1111);
        step(1'b1, 1'b0, 4'b1111);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'b1111);
        step(1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 4'b0000);

        // Second instance: WARMUP=0 goes straight to SERVE; 4-bit counter wraps.
        rst_b = 1'b1;
        bus_b.req = 2'b00;
        step(1'b0, 1'b0, '0);
        check("b_gen_rst_reset", 64'(bus_b.gen_rst), 64'(1));
        check("b_ready_reset", 64'(bus_b.ready), 64'(0));
        check("b_cnt_reset", 64'(bus_b.served_cnt), 64'(0));
        check("b_data_reset", 64'(bus_b.rnd_data), 64'(0));
        rst_b = 1'b0;
        bus_b.req = 2'b11;
        step(1'b0, 1'b0, '0);
        check("b_gen_rst_serve", 64'(bus_b.gen_rst), 64'(0));
        check("b_ready_serve", 64'(bus_b.ready), 64'(1));
        check("b_ack_first", 64'(bus_b.ack), 64'(0));
        for (int i = 1; i <= 17; i++) begin
            step(1'b0, 1'b0, '0);
            exp_ack_b = (i % 2 == 1) ? 2'b01 : 2'b10;
            check("b_ack", 64'(bus_b.ack), 64'(exp_ack_b));
            check("b_data", 64'(bus_b.rnd_data), 64'(bus.gen_word));
        end
        check("b_cnt_wrap", 64'(bus_b.served_cnt), 64'(1));
        bus_b.req = 2'b00;
        rst_b = 1'b1;
        step(1'b0, 1'b0, '0);

        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
